// File: rtl/bus_datapath_pkg.sv
// Shared types and index offsets for the single-bus datapath.
// Special-register offsets are relative to NUM_GPR inside src_en/dst_en.
package bus_datapath_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } hs_state_e;

    localparam int SRC_HI  = 0;
    localparam int SRC_LO  = 1;
    localparam int SRC_ZHI = 2;
    localparam int SRC_ZLO = 3;
    localparam int SRC_PC  = 4;
    localparam int SRC_MDR = 5;
    localparam int SRC_Y   = 6;

    localparam int DST_HI   = 0;
    localparam int DST_LO   = 1;
    localparam int DST_Y    = 2;
    localparam int DST_PC   = 3;
    localparam int DST_IR   = 4;
    localparam int DST_MAR  = 5;
    localparam int DST_MDR  = 6;
    localparam int DST_ZRSV = 7;

    function automatic int dst_width(input int num_gpr);
        return num_gpr + 8;
    endfunction

endpackage

// File: rtl/bus_datapath_p_reg.sv
// Generic datapath register with load enable and synchronous clear.
module bus_reg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Storage: clear wins over load.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            q_o <= '0;
        end else if (ld_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/bus_datapath_p.sv
// Single-bus CPU datapath: GPR bank, special registers, priority bus mux,
// sticky conflict flags and a MAR/MDR memory handshake engine with timeout.
module bus_datapath_p
    import bus_datapath_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_GPR     = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [NUM_GPR+6:0]            src_en,
    input  logic [dst_width(NUM_GPR)-1:0] dst_en,
    input  logic                          z_load,
    input  logic [2*DATA_W-1:0]           z_in,
    input  logic                          rd_start,
    input  logic                          wr_start,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             bus,
    output logic [DATA_W-1:0]             y_out,
    output logic [DATA_W-1:0]             ir_out,
    output logic                          bus_err,
    output logic                          cmd_err,
    output logic                          mem_err
);

    localparam int SRC_W = NUM_GPR + 7;
    localparam int DST_W = dst_width(NUM_GPR);
    localparam int NREG  = NUM_GPR + 7;
    localparam int I_MAR = NUM_GPR + DST_MAR;
    localparam int I_MDR = NUM_GPR + DST_MDR;
    localparam logic [7:0] TMO_C = 8'(MEM_TIMEOUT);

    logic [DATA_W-1:0]   reg_q     [NREG];
    logic [DATA_W-1:0]   reg_d_s   [NREG];
    logic [DATA_W-1:0]   src_val_s [SRC_W];
    logic [2*DATA_W-1:0] z_q;
    logic [NREG-1:0]     ld_s;
    logic [DATA_W-1:0]   bus_s;
    logic                multi_src_s;
    logic                busy_s;
    logic                rd_ack_s;
    logic                start_conflict_s;
    logic                mem_busy_dst_s;
    logic                rsvd_unused_s;

    hs_state_e  state_q;
    logic [7:0] cnt_q;
    logic       mem_req_q;
    logic       mem_we_q;
    logic       bus_err_q;
    logic       cmd_err_q;
    logic       mem_err_q;

    // Map bus-source index order onto the register storage.
    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) begin
            src_val_s[i] = reg_q[i];
        end
        src_val_s[NUM_GPR+SRC_HI]  = reg_q[NUM_GPR+DST_HI];
        src_val_s[NUM_GPR+SRC_LO]  = reg_q[NUM_GPR+DST_LO];
        src_val_s[NUM_GPR+SRC_ZHI] = z_q[2*DATA_W-1:DATA_W];
        src_val_s[NUM_GPR+SRC_ZLO] = z_q[DATA_W-1:0];
        src_val_s[NUM_GPR+SRC_PC]  = reg_q[NUM_GPR+DST_PC];
        src_val_s[NUM_GPR+SRC_MDR] = reg_q[I_MDR];
        src_val_s[NUM_GPR+SRC_Y]   = reg_q[NUM_GPR+DST_Y];
    end

    // Priority mux: scanning downward lets the lowest set index win.
    always_comb begin
        bus_s = '0;
        for (int i = SRC_W - 1; i >= 0; i--) begin
            if (src_en[i]) begin
                bus_s = src_val_s[i];
            end else begin
                bus_s = bus_s;
            end
        end
    end

    assign multi_src_s      = |(src_en & (src_en - SRC_W'(1)));
    assign busy_s           = (state_q != ST_IDLE);
    assign rd_ack_s         = (state_q == ST_RD_WAIT) && mem_ack;
    assign start_conflict_s = busy_s ? (rd_start | wr_start) : (rd_start & wr_start);
    assign mem_busy_dst_s   = busy_s && (dst_en[I_MAR] || dst_en[I_MDR]);
    assign rsvd_unused_s    = dst_en[DST_W-1];

    // Load enables; MAR/MDR are frozen while a transaction is outstanding.
    always_comb begin
        ld_s        = dst_en[NREG-1:0];
        ld_s[I_MAR] = dst_en[I_MAR] & ~busy_s;
        ld_s[I_MDR] = (dst_en[I_MDR] & ~busy_s) | rd_ack_s;
    end

    // Register data: read data takes MDR over the bus on an ack.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            reg_d_s[i] = bus_s;
        end
        if (rd_ack_s) begin
            reg_d_s[I_MDR] = mem_rdata;
        end else begin
            reg_d_s[I_MDR] = bus_s;
        end
    end

    for (genvar g = 0; g < NREG + 1; g++) begin : g_reg
        if (g < NREG) begin : g_word
            bus_reg #(.W(DATA_W)) u_reg (
                .clk_i (clk),
                .clr_i (clr),
                .ld_i  (ld_s[g]),
                .d_i   (reg_d_s[g]),
                .q_o   (reg_q[g])
            );
        end else begin : g_z
            bus_reg #(.W(2*DATA_W)) u_reg (
                .clk_i (clk),
                .clr_i (clr),
                .ld_i  (z_load),
                .d_i   (z_in),
                .q_o   (z_q)
            );
        end
    end

    // Handshake FSM, wait counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            bus_err_q <= 1'b0;
            cmd_err_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            if (multi_src_s) begin
                bus_err_q <= 1'b1;
            end
            if (start_conflict_s || mem_busy_dst_s) begin
                cmd_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rd_start && !wr_start) begin
                        state_q   <= ST_RD_WAIT;
                        cnt_q     <= 8'd0;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                    end else if (wr_start && !rd_start) begin
                        state_q   <= ST_WR_WAIT;
                        cnt_q     <= 8'd0;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                    end
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (mem_ack) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end else if (cnt_q + 8'd1 == TMO_C) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus       = bus_s;
    assign busy      = busy_s;
    assign done      = busy_s & mem_ack;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = reg_q[I_MAR];
    assign mem_wdata = reg_q[I_MDR];
    assign y_out     = reg_q[NUM_GPR+DST_Y];
    assign ir_out    = reg_q[NUM_GPR+DST_IR];
    assign bus_err   = bus_err_q;
    assign cmd_err   = cmd_err_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_bus_datapath_p.sv
// Scoreboard bench for bus_datapath_p: directed scenarios then random traffic,
// checked against a register-level behavioural model of the datapath.
module tb_bus_datapath_p;

    localparam int NG  = 8;
    localparam int W   = 32;
    localparam int TMO = 4;
    localparam int SW  = NG + 7;
    localparam int DW  = NG + 8;

    localparam int S_HI = NG, S_LO = NG + 1, S_ZHI = NG + 2, S_ZLO = NG + 3;
    localparam int S_PC = NG + 4, S_MDR = NG + 5, S_Y = NG + 6;
    localparam int D_HI = NG, D_LO = NG + 1, D_Y = NG + 2, D_PC = NG + 3;
    localparam int D_IR = NG + 4, D_MAR = NG + 5, D_MDR = NG + 6;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [SW-1:0] src_en = '0;
    logic [DW-1:0] dst_en = '0;
    logic          z_load = 1'b0;
    logic [2*W-1:0] z_in = '0;
    logic          rd_start = 1'b0, wr_start = 1'b0, mem_ack = 1'b0;
    logic [W-1:0]  mem_rdata = '0;
    logic          mem_req, mem_we, busy, done, bus_err, cmd_err, mem_err;
    logic [W-1:0]  mem_addr, mem_wdata, bus, y_out, ir_out;

    bus_datapath_p #(.DATA_W(W), .NUM_GPR(NG), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .clr(clr), .src_en(src_en), .dst_en(dst_en),
        .z_load(z_load), .z_in(z_in), .rd_start(rd_start), .wr_start(wr_start),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .bus(bus), .y_out(y_out), .ir_out(ir_out),
        .bus_err(bus_err), .cmd_err(cmd_err), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [W-1:0] m_gpr [NG];
    logic [W-1:0] m_hi, m_lo, m_y, m_pc, m_ir, m_mar, m_mdr, m_zhi, m_zlo;
    int  m_mode = 0;   // 0 idle, 1 reading, 2 writing
    int  m_wait = 0;
    bit  m_berr, m_cerr, m_merr;
    bit  m_valid = 1'b0;

    typedef struct {
        logic [W-1:0] bus, addr, wdata, y, ir;
        bit req, we, busy, done, berr, cerr, merr;
    } exp_t;
    typedef struct {
        logic [W-1:0] addr;
        bit we;
    } txn_t;
    exp_t cyc_q[$];
    txn_t done_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] m_src(input int i);
        if (i < NG) return m_gpr[i];
        case (i)
            S_HI:    return m_hi;
            S_LO:    return m_lo;
            S_ZHI:   return m_zhi;
            S_ZLO:   return m_zlo;
            S_PC:    return m_pc;
            S_MDR:   return m_mdr;
            S_Y:     return m_y;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] m_bus(input logic [SW-1:0] s);
        for (int i = 0; i < SW; i++) begin
            if (s[i]) return m_src(i);
        end
        return '0;
    endfunction

    function automatic logic [SW-1:0] oh_s(input int i);
        logic [SW-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] oh_d(input int i);
        logic [DW-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Apply one cycle of inputs and queue the outputs the model expects for it.
    task automatic drive(input logic [SW-1:0] s, input logic [DW-1:0] d, input bit zl,
                         input logic [2*W-1:0] zi, input bit rd, input bit wr,
                         input bit ack, input logic [W-1:0] rdat, input bit c);
        exp_t e;
        txn_t t;
        src_en = s; dst_en = d; z_load = zl; z_in = zi;
        rd_start = rd; wr_start = wr; mem_ack = ack; mem_rdata = rdat; clr = c;
        if (m_valid) begin
            e.bus = m_bus(s); e.addr = m_mar; e.wdata = m_mdr; e.y = m_y; e.ir = m_ir;
            e.req = (m_mode != 0); e.we = (m_mode == 2); e.busy = (m_mode != 0);
            e.done = (m_mode != 0) && ack;
            e.berr = m_berr; e.cerr = m_cerr; e.merr = m_merr;
            cyc_q.push_back(e);
            if (e.done) begin
                t.addr = m_mar;
                t.we = (m_mode == 2);
                done_q.push_back(t);
            end
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [W-1:0] b;
        bit bsy;
        if (clr) begin
            for (int i = 0; i < NG; i++) m_gpr[i] = '0;
            m_hi = '0; m_lo = '0; m_y = '0; m_pc = '0; m_ir = '0;
            m_mar = '0; m_mdr = '0; m_zhi = '0; m_zlo = '0;
            m_mode = 0; m_wait = 0; m_berr = 0; m_cerr = 0; m_merr = 0;
            m_valid = 1'b1;
            return;
        end
        b = m_bus(src_en);
        bsy = (m_mode != 0);
        if ($countones(src_en) > 1) m_berr = 1;
        if ((bsy && (rd_start || wr_start)) || (!bsy && rd_start && wr_start) ||
            (bsy && (dst_en[D_MAR] || dst_en[D_MDR]))) m_cerr = 1;
        for (int i = 0; i < NG; i++) if (dst_en[i]) m_gpr[i] = b;
        if (dst_en[D_HI]) m_hi = b;
        if (dst_en[D_LO]) m_lo = b;
        if (dst_en[D_Y])  m_y  = b;
        if (dst_en[D_PC]) m_pc = b;
        if (dst_en[D_IR]) m_ir = b;
        if (dst_en[D_MAR] && !bsy) m_mar = b;
        if (m_mode == 1 && mem_ack) m_mdr = mem_rdata;
        else if (dst_en[D_MDR] && !bsy) m_mdr = b;
        if (z_load) begin
            m_zhi = z_in[2*W-1:W];
            m_zlo = z_in[W-1:0];
        end
        if (!bsy) begin
            if (rd_start != wr_start) begin
                m_mode = rd_start ? 1 : 2;
                m_wait = 0;
            end
        end else if (mem_ack) begin
            m_mode = 0;
        end else begin
            m_wait++;
            if (m_wait == TMO) begin
                m_mode = 0;
                m_merr = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
    endtask

    task automatic load_reg(input int d, input logic [W-1:0] v);
        drive('0, '0, 1'b1, {32'h0, v}, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        drive(oh_s(S_ZLO), oh_d(d), 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
    endtask

    // Monitor: per-cycle output scoreboard plus transaction completions.
    always @(negedge clk) begin
        exp_t e;
        txn_t t;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("bus", bus, e.bus);
            check("mem_addr", mem_addr, e.addr);
            check("mem_wdata", mem_wdata, e.wdata);
            check("y_out", y_out, e.y);
            check("ir_out", ir_out, e.ir);
            check("ctl{req,we,busy,done}", W'({mem_req, mem_we, busy, done}),
                  W'({e.req, e.we, e.busy, e.done}));
            check("flags{bus,cmd,mem}", W'({bus_err, cmd_err, mem_err}),
                  W'({e.berr, e.cerr, e.merr}));
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", W'(1), W'(0));
            end else begin
                t = done_q.pop_front();
                check("done_addr", mem_addr, t.addr);
                check("done_we", W'(mem_we), W'(t.we));
            end
        end
    end

    int reqc, wec, donec;

    initial begin
        drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        tick();

        // Reset clears a loaded register and all status.
        load_reg(3, 32'hDEADBEEF);
        drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        tick();
        drive(oh_s(3), '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1 check("rst_r3", bus, 32'h0);
        check("rst_status", W'({bus_err, cmd_err, mem_err, busy, mem_req, done}), W'(0));
        tick();

        // Register transfer R1 -> {R2, Y}.
        load_reg(1, 32'h12345678);
        drive(oh_s(1), oh_d(2) | oh_d(D_Y), 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("xfer_y_out", y_out, 32'h12345678);
        drive(oh_s(2), '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1 check("xfer_r2", bus, 32'h12345678);
        tick();

        // Bus conflict: lowest index wins, flag sticks.
        load_reg(0, 32'hA);
        load_reg(5, 32'hB);
        drive(oh_s(0) | oh_s(5), '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1 check("conflict_bus", bus, 32'hA);
        check("conflict_err_before", W'(bus_err), W'(0));
        tick();
        check("conflict_err_after", W'(bus_err), W'(1));
        drive(oh_s(1), oh_d(4), 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("conflict_err_sticky", W'(bus_err), W'(1));

        // Read with ack in the third wait cycle.
        load_reg(D_MAR, 32'h40);
        drive('0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        reqc = 0; donec = 0;
        for (int k = 0; k < 3; k++) begin
            drive('0, '0, 1'b0, '0, 1'b0, 1'b0, (k == 2), (k == 2) ? 32'hCAFEF00D : $urandom(), 1'b0);
            #1 reqc += int'(mem_req);
            donec += int'(done);
            if (k == 0) check("rd_addr", mem_addr, 32'h40);
            tick();
        end
        drive(oh_s(S_MDR), '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1 check("rd_req_low_after", W'(mem_req), W'(0));
        check("rd_mdr", bus, 32'hCAFEF00D);
        tick();
        check("rd_req_cycles", W'(reqc), W'(3));
        check("rd_done_pulses", W'(donec), W'(1));

        // Write that never gets an ack times out.
        drive('0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        reqc = 0; wec = 0; donec = 0;
        for (int k = 0; k < 8; k++) begin
            drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
            #1 reqc += int'(mem_req);
            wec += int'(mem_we);
            donec += int'(done);
            tick();
        end
        check("tmo_req_cycles", W'(reqc), W'(TMO));
        check("tmo_we_cycles", W'(wec), W'(TMO));
        check("tmo_no_done", W'(donec), W'(0));
        check("tmo_mem_err", W'(mem_err), W'(1));
        check("tmo_idle", W'(busy), W'(0));

        // Simultaneous read and write starts.
        check("cmd_err_clean", W'(cmd_err), W'(0));
        drive('0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        check("both_cmd_err", W'(cmd_err), W'(1));
        check("both_no_req", W'(mem_req), W'(0));

        // MDR bus load colliding with a read ack: memory data wins.
        drive('0, '0, 1'b1, {32'h0, 32'h11111111}, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        drive('0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        drive(oh_s(S_ZLO), oh_d(D_MDR), 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h55AA55AA, 1'b0);
        tick();
        drive(oh_s(S_MDR), '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1 check("ack_vs_dst_mdr", bus, 32'h55AA55AA);
        tick();

        // clr in the middle of a wait aborts the transaction.
        drive('0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        idle();
        check("midwait_req_high", W'(mem_req), W'(1));
        drive('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        tick();
        check("clr_abort_req", W'(mem_req), W'(0));
        check("clr_abort_busy", W'(busy), W'(0));

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [SW-1:0] s;
            logic [DW-1:0] d;
            int r;
            r = $urandom_range(0, 9);
            if (r < 7) s = oh_s($urandom_range(0, SW - 1));
            else if (r == 7) s = '0;
            else s = SW'($urandom());
            d = DW'($urandom() & $urandom() & $urandom());
            drive(s, d, ($urandom_range(0, 3) == 0), {$urandom(), $urandom()},
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0), $urandom(),
                  ($urandom_range(0, 255) == 0));
            tick();
        end

        idle();
        idle();
        check("done_queue_drained", W'(done_q.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_datapath_p.md
# bus_datapath_p

Parametrised single-bus CPU datapath: a bank of general-purpose registers plus the HI, LO, Z(high/low), PC, IR, MAR, MDR and Y special registers, all sharing one source-selected internal bus. It replaces the fixed 32-bit, 16-register datapath. It adds a memory read/write handshake engine behind MAR/MDR with a timeout, and sticky error flags for bus and command conflicts. The block sits between the control unit, which drives the one-hot enables, and the ALU and memory.

## Interface
Parameters:
- DATA_W, 32, bus and register width.
- NUM_GPR, 16, number of general-purpose registers (2..64).
- MEM_TIMEOUT, 15, maximum number of wait cycles for mem_ack before abort (1..255).

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  reset; synchronous, active-high.
- src_en  in  NUM_GPR+7  one-hot bus-source select, in index order: GPR0..GPR(N-1), HI, LO, ZHI, ZLO, PC, MDR, Y.
- dst_en  in  NUM_GPR+8  bus-destination load mask (multi-hot allowed), in index order: GPR0..GPR(N-1), HI, LO, Y, PC, IR, MAR, MDR, Z-unused-reserved (ignored).
- z_load  in  1  load Z from the ALU result.
- z_in  in  2*DATA_W  ALU result; the upper half goes to ZHI and the lower half to ZLO.
- rd_start / wr_start  in  1  start a memory read or write.
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier, valid while mem_req is high.
- mem_addr  out  DATA_W  address, always equal to MAR.
- mem_wdata  out  DATA_W  write data, always equal to MDR.
- mem_rdata  in  DATA_W  read data.
- mem_ack  in  1  one-cycle completion pulse from memory.
- busy  out  1  handshake engine is not in IDLE.
- done  out  1  one-cycle pulse on successful completion.
- bus  out  DATA_W  current bus value.
- y_out  out  DATA_W  Y register value, for the ALU A operand.
- ir_out  out  DATA_W  IR value, for the control unit.
- bus_err / cmd_err / mem_err  out  1  sticky error flags; cleared only by clr.

## Operation
- Bus selection:
  - bus is a combinational function of src_en.
  - With no source selected, bus is 0.
  - With more than one source selected, the lowest set index drives the bus and bus_err is set at the next edge.
- Register loads: every register whose dst_en bit is set loads bus at the rising edge. A register may be both source and destination in the same cycle; it keeps its old value on the bus for that cycle and loads the new value at the edge.
- Z register: on z_load, ZHI <= z_in[2W-1:W] and ZLO <= z_in[W-1:0]. Z is not a bus destination.
- Handshake FSM: states IDLE, RD_WAIT, WR_WAIT.
  - IDLE, rd_start only: go to RD_WAIT.
  - IDLE, wr_start only: go to WR_WAIT.
  - IDLE, both starts: stay in IDLE and set cmd_err.
  - Any start while busy is ignored and sets cmd_err.
  - In RD_WAIT or WR_WAIT: mem_req=1, and mem_we=1 in WR_WAIT only.
  - RD_WAIT with mem_ack: MDR <= mem_rdata, done=1 in that cycle, go to IDLE.
  - WR_WAIT with mem_ack: done=1, go to IDLE.
- Wait counter:
  - Cleared on entry to a wait state.
  - Increments on every wait cycle without mem_ack.
  - When it reaches MEM_TIMEOUT without an ack, the FSM returns to IDLE, mem_err is set, done stays 0 and MDR is unchanged.
- Conflict rules:
  - A dst_en load of MDR in the same cycle as a read ack is dropped; mem_rdata wins.
  - While busy, dst_en loads of MAR and MDR are ignored and set cmd_err. This keeps mem_addr and mem_wdata stable.
- mem_ack seen in IDLE is ignored.

## Timing
- Reset: on a clr edge, all registers become 0, FSM goes to IDLE, counter becomes 0, and all error flags become 0. Consequently mem_req, mem_we, busy and done are all 0.
- clr asserted mid-transaction aborts it immediately. mem_req is 0 in the following cycle and no done pulse is produced.
- Bus path: zero latency from src_en to bus. Destination registers update one edge later.
- Memory sequencing:
  - start sampled at edge t;
  - mem_req is high from cycle t+1;
  - the earliest ack is in cycle t+1;
  - done is combinational in the ack cycle;
  - mem_req is low in the cycle after the ack.
- Best-case transaction is 1 cycle in a wait state. Worst case is MEM_TIMEOUT cycles, then abort.
- A new start is accepted in the cycle after done, i.e. once busy is 0.

## Structure
- Package bus_datapath_pkg holds:
  - the FSM state enum;
  - localparams for the special-register index offsets relative to NUM_GPR (SRC_HI=0 … SRC_Y=6; DST_HI=0 … DST_MDR=6);
  - a function giving the width of NUM_GPR+8.
- Sub-module bus_reg, a DATA_W register with load enable and synchronous clr, instantiated NUM_GPR+8 times via generate.
- The priority bus mux, conflict detection and handshake FSM live in the top module.

## Test plan
- Reset: load R3=0xDEADBEEF, assert clr for one cycle. All registers read 0 via bus, all flags are 0, and busy=0.
- Transfer: src=R1 (0x12345678) with dst mask {R2, Y}. Next cycle R2=Y=0x12345678 and y_out matches.
- Bus conflict: src_en has R0 (0xA) and R5 (0xB) set. bus=0xA and bus_err=1 from the next cycle onward, including after a clean transfer.
- Read: MAR=0x40, rd_start, mem_ack after 3 cycles with mem_rdata=0xCAFEF00D. mem_req is high for 3 cycles, mem_addr=0x40, MDR=0xCAFEF00D, one done pulse.
- Timeout: MEM_TIMEOUT=4, wr_start, no ack. mem_req and mem_we stay high for 4 cycles, then FSM is IDLE, mem_err=1 and done never pulses.
- Simultaneous events:
  - rd_start together with wr_start: cmd_err=1 and no mem_req.
  - During a read, a dst_en load of MDR in the ack cycle: MDR equals mem_rdata.
  - clr mid-wait: mem_req is 0 the next cycle.
